// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU control definitions: trap state encoding, address width, save word codes
package cpu_pkg;

  localparam int CPU_ADDR_W = 16;

  typedef enum logic [2:0] {
    TRAP_IDLE   = 3'd0,
    TRAP_SAVE_A = 3'd1,
    TRAP_SAVE_W = 3'd2,
    TRAP_VEC_A  = 3'd3,
    TRAP_VEC_R  = 3'd4,
    TRAP_LOAD   = 3'd5,
    TRAP_ACK    = 3'd6
  } trap_state_t;

  // Context word codes driven on save_sel; further indices are CPU-specific extras
  localparam logic [2:0] SAVE_SEL_PSW = 3'd0;
  localparam logic [2:0] SAVE_SEL_PC  = 3'd1;

endpackage

// File: rtl/trap_arbiter.sv
// rtl/trap_arbiter.sv - combinational trap channel pick; round-robin from rr_ptr when TRAP_RR_PRIO_EN, else lowest index
module trap_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pending,
`ifdef TRAP_RR_PRIO_EN
  input  logic [CH_W-1:0]   rr_ptr,
`endif
  output logic [CH_W-1:0]   ch
);

`ifdef TRAP_RR_PRIO_EN
  int   j;
  logic found;

  always_comb begin
    ch    = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!found && pending[j]) begin
        ch    = CH_W'(j);
        found = 1'b1;
      end
    end
  end
`else
  // Scan downward so the lowest pending index is the last (winning) assignment
  always_comb begin
    ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) ch = CH_W'(i);
    end
  end
`endif

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - multi-channel trap entry sequencer (context save, vector fetch, PC load, ack)
// Optional macro TRAP_RR_PRIO_EN selects round-robin arbitration instead of fixed lowest-index priority.
module trap_sequencer
  import cpu_pkg::*;
#(
  parameter int                NUM_CH     = 4,
  parameter int                ADDR_W     = CPU_ADDR_W,
  parameter int                SAVE_WORDS = 2,
  parameter logic [ADDR_W-1:0] VEC_BASE   = '0,
  parameter int                VEC_STRIDE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] irq_req,
  input  logic [NUM_CH-1:0] irq_mask,
  input  logic              privileged,
  input  logic              boundary,
  input  logic              mem_ready,
  output logic              take,
  output logic              busy,
  output logic              sp_dec,
  output logic [2:0]        save_sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              vec_mar,
  output logic              load_pc,
  output logic [NUM_CH-1:0] irq_ack
);

  localparam int                CH_W   = $clog2(NUM_CH);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(VEC_STRIDE);
  localparam logic [2:0]        LAST   = 3'(SAVE_WORDS - 1);

  trap_state_t       state, state_nxt;
  logic [CH_W-1:0]   ch, arb_ch;
  logic [2:0]        idx;
  logic [NUM_CH-1:0] pending;
  logic [ADDR_W-1:0] vec_nxt;

  assign pending = irq_req & ~irq_mask;
  // Gated by reset_n so the CU never sees an acceptance while the sequencer is held in reset
  assign take    = reset_n & (state == TRAP_IDLE) & boundary & ~privileged & (|pending);
  assign vec_nxt = VEC_BASE + ADDR_W'(arb_ch) * STRIDE;

`ifdef TRAP_RR_PRIO_EN
  logic [CH_W-1:0] rr_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (state == TRAP_ACK) begin
      rr_ptr <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
    end
  end

  trap_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .ch      (arb_ch)
  );
`else
  trap_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .pending (pending),
    .ch      (arb_ch)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= TRAP_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TRAP_IDLE:   if (take) state_nxt = TRAP_SAVE_A;
      TRAP_SAVE_A: state_nxt = TRAP_SAVE_W;
      TRAP_SAVE_W: if (mem_ready) state_nxt = (idx == LAST) ? TRAP_VEC_A : TRAP_SAVE_A;
      TRAP_VEC_A:  state_nxt = TRAP_VEC_R;
      TRAP_VEC_R:  if (mem_ready) state_nxt = TRAP_LOAD;
      TRAP_LOAD:   state_nxt = TRAP_ACK;
      TRAP_ACK:    state_nxt = TRAP_IDLE;
      default:     state_nxt = TRAP_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != TRAP_IDLE);
    sp_dec   = 1'b0;
    save_sel = 3'd0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    vec_mar  = 1'b0;
    load_pc  = 1'b0;
    irq_ack  = '0;
    case (state)
      TRAP_SAVE_A: begin
        sp_dec   = 1'b1;
        save_sel = idx;
      end
      TRAP_SAVE_W: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        save_sel = idx;
      end
      TRAP_VEC_A:  vec_mar = 1'b1;
      TRAP_VEC_R:  mem_req = 1'b1;
      TRAP_LOAD:   load_pc = 1'b1;
      TRAP_ACK:    irq_ack = {{(NUM_CH-1){1'b0}}, 1'b1} << ch;
      default:     ;
    endcase
  end

  // Channel and vector are frozen at take; later request/mask changes cannot redirect the sequence
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch       <= '0;
      idx      <= SAVE_SEL_PSW;
      vec_addr <= '0;
    end else if (take) begin
      ch       <= arb_ch;
      idx      <= SAVE_SEL_PSW;
      vec_addr <= vec_nxt;
    end else if (state == TRAP_SAVE_W && mem_ready && idx != LAST) begin
      idx <= idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - self-checking bench for trap_sequencer against a timeline reference model
module tb_trap_sequencer;

  localparam int          N         = 4;
  localparam int          SW        = 2;
  localparam logic [15:0] TB_BASE   = 16'h0000;
  localparam int          TB_STRIDE = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  irq_req, irq_mask, irq_ack;
  logic          privileged, boundary, mem_ready;
  logic          take, busy, sp_dec, mem_req, mem_we, vec_mar, load_pc;
  logic [2:0]    save_sel;
  logic [15:0]   vec_addr;
  logic [29:0]   obs;

  int tests = 0;
  int fails = 0;
  int rr_model = 0;

  typedef struct {
    logic [29:0] exp;
    logic        rdy;
  } step_t;

  trap_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_req    (irq_req),
    .irq_mask   (irq_mask),
    .privileged (privileged),
    .boundary   (boundary),
    .mem_ready  (mem_ready),
    .take       (take),
    .busy       (busy),
    .sp_dec     (sp_dec),
    .save_sel   (save_sel),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .vec_addr   (vec_addr),
    .vec_mar    (vec_mar),
    .load_pc    (load_pc),
    .irq_ack    (irq_ack)
  );

  always #5 clk = ~clk;

  assign obs = {take, busy, sp_dec, save_sel, mem_req, mem_we, vec_mar, load_pc, irq_ack, vec_addr};

  task automatic chk(input string tag, input logic [29:0] o, input logic [29:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_take);
    chk(tag, {obs[29:16], 16'h0}, {exp_take, 29'b0});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] p);
`ifdef TRAP_RR_PRIO_EN
    for (int i = 0; i < N; i++)
      if (p[(rr_model + i) % N]) return (rr_model + i) % N;
`else
    for (int i = 0; i < N; i++)
      if (p[i]) return i;
`endif
    return -1;
  endfunction

  function automatic logic [29:0] ex(input logic sp, input int ss, input logic mr, input logic mw,
                                     input logic vm, input logic lp, input logic [N-1:0] ack,
                                     input logic [15:0] va);
    return {1'b0, 1'b1, sp, 3'(ss), mr, mw, vm, lp, ack, va};
  endfunction

  // One trap attempt: ws/wv = not-ready cycles per save write / vector read; abort_at = timeline step to reset in
  task automatic run_trap(input logic [N-1:0] req, input logic [N-1:0] mask, input int ws, input int wv,
                          input bit perturb, input int abort_at, input string tag);
    logic [N-1:0] p;
    logic [15:0]  va;
    int           ch;
    step_t        tl[$];
    tick();
    irq_req    = req;
    irq_mask   = mask;
    privileged = 1'b0;
    boundary   = 1'b1;
    mem_ready  = 1'($urandom);
    #1;
    p = req & ~mask;
    if (p == '0) begin
      chk_idle({tag, "/no_take"}, 1'b0);
      boundary = 1'b0;
      return;
    end
    chk_idle({tag, "/take"}, 1'b1);
    ch = pick(p);
    va = TB_BASE + 16'(ch * TB_STRIDE);
    for (int k = 0; k < SW; k++) begin
      tl.push_back('{ex(1, k, 0, 0, 0, 0, '0, va), 1'($urandom)});
      for (int w = 0; w <= ws; w++) tl.push_back('{ex(0, k, 1, 1, 0, 0, '0, va), (w == ws)});
    end
    tl.push_back('{ex(0, 0, 0, 0, 1, 0, '0, va), 1'($urandom)});
    for (int w = 0; w <= wv; w++) tl.push_back('{ex(0, 0, 1, 0, 0, 0, '0, va), (w == wv)});
    tl.push_back('{ex(0, 0, 0, 0, 0, 1, '0, va), 1'($urandom)});
    tl.push_back('{ex(0, 0, 0, 0, 0, 0, N'(1) << ch, va), 1'($urandom)});
    foreach (tl[i]) begin
      tick();
      mem_ready = tl[i].rdy;
      if (perturb) begin
        boundary   = 1'($urandom);
        irq_req    = N'($urandom);
        irq_mask   = N'($urandom);
        privileged = 1'($urandom);
      end else begin
        boundary = 1'b0;
      end
      if (i == abort_at) begin
        #1;
        reset_n = 1'b0;
        #1;
        chk({tag, "/async_reset"}, obs, 30'b0);
        tick();
        chk({tag, "/held_reset"}, obs, 30'b0);
        reset_n  = 1'b1;
        boundary = 1'b0;
        return;
      end
      #1;
      chk($sformatf("%s/step%0d", tag, i), obs, tl[i].exp);
    end
`ifdef TRAP_RR_PRIO_EN
    rr_model = (ch + 1) % N;
`endif
    boundary = 1'b0;
  endtask

  task automatic gate(input logic [N-1:0] req, input logic [N-1:0] mask, input logic priv, input string tag);
    for (int i = 0; i < 20; i++) begin
      tick();
      irq_req    = req;
      irq_mask   = mask;
      privileged = priv;
      boundary   = 1'b1;
      mem_ready  = 1'($urandom);
      #1;
      chk_idle(tag, 1'b0);
    end
    boundary = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    irq_req    = '1;
    irq_mask   = '0;
    privileged = 1'b0;
    boundary   = 1'b1;
    mem_ready  = 1'b1;
    #12;
    chk("reset_state", obs, 30'b0);
    @(negedge clk);
    reset_n  = 1'b1;
    boundary = 1'b0;

    run_trap(4'b0100, 4'b0000, 0, 0, 0, -1, "single");

    run_trap(4'b1010, 4'b0000, 0, 0, 0, -1, "prio_a");
    run_trap(4'b1000, 4'b0000, 0, 0, 0, -1, "prio_b");
    run_trap(4'b1010, 4'b0000, 0, 0, 0, -1, "prio_c");
    run_trap(4'b1000, 4'b0000, 0, 0, 0, -1, "prio_d");
    for (int i = 0; i < 4; i++) run_trap(4'b1111, 4'b0000, 0, 0, 0, -1, "all_held");

    gate(4'b0010, 4'b0000, 1'b1, "gate_priv");
    gate(4'b0110, 4'b0110, 1'b0, "gate_mask");
    run_trap(4'b0010, 4'b0000, 0, 0, 0, -1, "priv_cleared");

    run_trap(4'b0001, 4'b0000, 3, 3, 0, -1, "wait_states");
    run_trap(4'b0110, 4'b0000, 1, 1, 1, -1, "mid_seq");

    run_trap(4'b0001, 4'b0000, 0, 2, 0, SW * 2 + 1, "reset_vec_r");
    run_trap(4'b0100, 4'b0000, 0, 0, 0, -1, "post_reset");

    for (int i = 0; i < 40; i++)
      run_trap(N'($urandom), N'($urandom & $urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 1'($urandom), -1, "random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
